// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types, note divider table and melody table for the note sequencer
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GATE = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    // Melody entry layout: {note[7:4], len[3:0]}
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int LEN_MSB  = 3;
    localparam int LEN_LSB  = 0;

    localparam int NOTE_DIV_W = 24;

    // Entry 0 is the rest slot and is never loaded into duty.
    localparam logic [NOTE_DIV_W-1:0] NOTE_DIV [0:15] = '{
        24'd0,      24'd191113, 24'd180388, 24'd170265,
        24'd160705, 24'd151685, 24'd143172, 24'd135139,
        24'd127551, 24'd120395, 24'd113636, 24'd107259,
        24'd101239, 24'd95557,  24'd90194,  24'd85131
    };

    localparam int MELODY_LEN = 16;

    localparam logic [7:0] MELODY [0:MELODY_LEN-1] = '{
        8'h31, 8'h00, 8'h52, 8'h10,
        8'h63, 8'h71, 8'h82, 8'h00,
        8'h93, 8'hA1, 8'hB0, 8'hC2,
        8'hD1, 8'hE0, 8'hF3, 8'h40
    };

    // Sequencers with more than MELODY_LEN steps replay the table from the top.
    function automatic logic [7:0] melody_entry(input logic [31:0] idx);
        return MELODY[idx[3:0]];
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - note gate / PWM divider interface between sequencer and envelope
// Signals: note_on_o (gate), duty_o[BW-1:0] (divider word).
// Modports: master (sequencer drives), slave (envelope receives).
interface note_sequencer_if #(
    parameter int BW = 24
);
    logic          note_on_o;
    logic [BW-1:0] duty_o;

    modport master (output note_on_o, output duty_o);
    modport slave  (input  note_on_o, input  duty_o);
endinterface

// File: rtl/note_seq_prescaler.sv
// rtl/note_seq_prescaler.sv - wrapping counter with one-cycle terminal-count pulse
// Ports: clk_i, rst_ni (sync, active-low), clr_i (force to 0), en_i (count enable),
//        term_i[W-1:0] (terminal count), tick_o (high while enabled at terminal count).
module note_seq_prescaler #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == term_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == term_i) ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - melody sequencer driving note gate and PWM divider word
// Ports: clk_i, rst_ni (sync, active-low), start_i, stop_i, loop_i,
//        tempo_i[7:0] (only with NOTE_SEQ_TEMPO_EN), note_if (master: note_on_o, duty_o),
//        busy_o (not IDLE), step_o (current melody step).
// Option: NOTE_SEQ_TEMPO_EN - tick period becomes (tempo_i+1) << TEMPO_SHIFT, latched per step.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int BW          = 24,
    parameter int STEPS       = 16,
    parameter int TICK_DIV    = 1_000_000,
    parameter int GAP_TICKS   = 2,
    parameter int TEMPO_SHIFT = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
`ifdef NOTE_SEQ_TEMPO_EN
    input  logic [7:0]               tempo_i,
`endif
    note_sequencer_if.master         note_if,
    output logic                     busy_o,
    output logic [$clog2(STEPS)-1:0] step_o
);

    localparam int SW       = $clog2(STEPS);
    // Prescaler wide enough for either tick source so both builds share one datapath.
    localparam int PW_DIV   = $clog2(TICK_DIV + 1);
    localparam int PW_TEMPO = 9 + TEMPO_SHIFT;
    localparam int PW       = (PW_DIV > PW_TEMPO) ? PW_DIV : PW_TEMPO;
    localparam int TW_GAP   = $clog2(GAP_TICKS + 1);
    localparam int TW       = (TW_GAP > 4) ? TW_GAP : 4;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic          note_on_q, note_on_d;
    logic [BW-1:0] duty_q, duty_d;

    logic [7:0]    entry;
    logic [3:0]    note;
    logic [3:0]    len;

    logic          cnt_clr;
    logic          presc_en;
    logic [PW-1:0] presc_term;
    logic          presc_tick;
    logic [TW-1:0] tcnt_term;
    logic          phase_done;

    assign entry = melody_entry(32'(step_q));
    assign note  = entry[NOTE_MSB:NOTE_LSB];
    assign len   = entry[LEN_MSB:LEN_LSB];

`ifdef NOTE_SEQ_TEMPO_EN
    logic [7:0] tempo_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tempo_q <= '0;
        end else if (state_q == ST_LOAD) begin
            tempo_q <= tempo_i;
        end
    end

    assign presc_term = ((PW'(tempo_q) + PW'(1)) << TEMPO_SHIFT) - PW'(1);
`else
    assign presc_term = PW'(TICK_DIV - 1);
`endif

    // Counters are held at zero in IDLE and LOAD so each GATE starts on a fresh tick.
    assign cnt_clr   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign presc_en  = (state_q == ST_GATE) || (state_q == ST_GAP);
    // The tick counter wraps on its own terminal tick, so GAP starts from zero
    // without an explicit clear on the GATE->GAP transition.
    assign tcnt_term = (state_q == ST_GATE) ? TW'(len) : TW'(GAP_TICKS - 1);

    note_seq_prescaler #(.W(PW)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (presc_en),
        .term_i (presc_term),
        .tick_o (presc_tick)
    );

    note_seq_prescaler #(.W(TW)) u_tick_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (presc_tick),
        .term_i (tcnt_term),
        .tick_o (phase_done)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        note_on_d = note_on_q;
        duty_d    = duty_q;

        // Stop overrides everything, including a pending duty load in LOAD.
        if (stop_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            note_on_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    note_on_d = 1'b0;
                    if (start_i && !stop_i) begin
                        state_d = ST_LOAD;
                        step_d  = '0;
                    end
                end
                ST_LOAD: begin
                    if (note != 4'd0) begin
                        duty_d = BW'(NOTE_DIV[note]);
                    end
                    note_on_d = (note != 4'd0);
                    state_d   = ST_GATE;
                end
                ST_GATE: begin
                    if (phase_done) begin
                        note_on_d = 1'b0;
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    note_on_d = 1'b0;
                    if (phase_done) begin
                        if (step_q < LAST_STEP) begin
                            step_d  = step_q + SW'(1);
                            state_d = ST_LOAD;
                        end else if (loop_i) begin
                            step_d  = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    note_on_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            note_on_q <= 1'b0;
            duty_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            note_on_q <= note_on_d;
            duty_q    <= duty_d;
        end
    end

    assign note_if.note_on_o = note_on_q;
    assign note_if.duty_o    = duty_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign step_o            = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with a timeline reference model
module tb_note_sequencer;

    localparam int STEPS  = 4;
    localparam int GAP    = 1;
    localparam int TDIV   = 4;
    localparam int TSHIFT = 2;
    localparam int P      = 4;

    localparam logic [7:0]  MEL [0:3]  = '{8'h31, 8'h00, 8'h52, 8'h10};
    localparam logic [23:0] ND  [0:15] = '{
        24'd0,      24'd191113, 24'd180388, 24'd170265,
        24'd160705, 24'd151685, 24'd143172, 24'd135139,
        24'd127551, 24'd120395, 24'd113636, 24'd107259,
        24'd101239, 24'd95557,  24'd90194,  24'd85131
    };

    typedef struct {
        int unsigned cyc;
        logic        on;
        logic [23:0] duty;
        logic        busy;
        logic [1:0]  step;
    } ev_t;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic       stop_i;
    logic       loop_i;
    logic       busy_o;
    logic [1:0] step_o;
`ifdef NOTE_SEQ_TEMPO_EN
    logic [7:0] tempo_i;
`endif

    note_sequencer_if #(.BW(24)) nif ();

    note_sequencer #(
        .BW          (24),
        .STEPS       (STEPS),
        .TICK_DIV    (TDIV),
        .GAP_TICKS   (GAP),
        .TEMPO_SHIFT (TSHIFT)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .stop_i  (stop_i),
        .loop_i  (loop_i),
`ifdef NOTE_SEQ_TEMPO_EN
        .tempo_i (tempo_i),
`endif
        .note_if (nif),
        .busy_o  (busy_o),
        .step_o  (step_o)
    );

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned busy_cnt = 0;
    bit          mon_en = 0;

    ev_t         exp_q[$];
    ev_t         mon_e;

    logic        m_on, m_busy;
    logic [23:0] m_duty;
    logic [1:0]  m_step;

    logic        p_on, p_busy;
    logic [23:0] p_duty;
    logic [1:0]  p_step;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Push an expected output change; identical consecutive states are not visible events.
    task automatic emit(input int unsigned t, input logic on, input logic [23:0] d,
                        input logic b, input logic [1:0] s);
        ev_t ev;
        if (on !== m_on || d !== m_duty || b !== m_busy || s !== m_step) begin
            ev.cyc = t; ev.on = on; ev.duty = d; ev.busy = b; ev.step = s;
            exp_q.push_back(ev);
        end
        m_on = on; m_duty = d; m_busy = b; m_step = s;
    endtask

    // Expected timeline of a playback started at edge e and cut at edge cut
    // (stop or reset), built from step lengths: LOAD 1, GATE (len+1)*P, GAP GAP*P.
    task automatic plan(input int unsigned e, input bit lp, input int unsigned cut,
                        input bit is_reset, output int unsigned last);
        int unsigned t, t1, tg, tp;
        int          step;
        bit          done;
        logic [7:0]  ent;
        logic [3:0]  note, len;
        logic [23:0] d;
        t = e; step = 0; done = 0; last = e;
        emit(t, 1'b0, m_duty, 1'b1, 2'd0);
        while (!done) begin
            ent  = MEL[step];
            note = ent[7:4];
            len  = ent[3:0];
            t1 = t + 1;
            if (t1 >= cut) break;
            d = (note != 0) ? ND[note] : m_duty;
            emit(t1, note != 0, d, 1'b1, 2'(step));
            tg = t1 + (int'(len) + 1) * P;
            if (tg >= cut) break;
            emit(tg, 1'b0, m_duty, 1'b1, 2'(step));
            tp = tg + GAP * P;
            if (tp >= cut) break;
            if (step < STEPS - 1) begin
                step++;
                emit(tp, 1'b0, m_duty, 1'b1, 2'(step));
                t = tp;
            end else if (lp) begin
                step = 0;
                emit(tp, 1'b0, m_duty, 1'b1, 2'd0);
                t = tp;
            end else begin
                emit(tp, 1'b0, m_duty, 1'b0, 2'(step));
                done = 1;
                last = tp;
            end
        end
        if (is_reset) begin
            emit(cut, 1'b0, 24'd0, 1'b0, 2'd0);
            last = cut;
        end else if (!done) begin
            emit(cut, 1'b0, m_duty, 1'b0, m_step);
            last = cut;
        end
    endtask

    // kind: 0 = play out, 1 = stop at e+off, 2 = reset at e+off
    task automatic run_play(input bit lp, input int hold, input int off, input int kind);
        int unsigned e, cut, last, fin;
        @(negedge clk);
        e   = cyc + 1;
        cut = (kind == 0) ? 32'hFFFF_FFFF : e + off;
        plan(e, lp, cut, kind == 2, last);
        loop_i  = lp;
        start_i = 1'b1;
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        if (kind != 0) begin
            while (cyc < cut - 1) @(negedge clk);
            if (kind == 1) stop_i = 1'b1;
            else           rst_ni = 1'b0;
            @(negedge clk);
            stop_i = 1'b0;
            rst_ni = 1'b1;
        end
        fin = (kind != 0 && cut > last) ? cut : last;
        while (cyc < fin + 2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        loop_i = 1'b0;
    endtask

    // Monitor: every visible output change must match the next scheduled event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (nif.note_on_o !== p_on || nif.duty_o !== p_duty ||
                busy_o !== p_busy || step_o !== p_step) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_change: cycle %0d on=%0d duty=%0d busy=%0d step=%0d, none scheduled",
                             cyc, nif.note_on_o, nif.duty_o, busy_o, step_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_cycle", cyc,        mon_e.cyc);
                    chk("note_on",     nif.note_on_o, mon_e.on);
                    chk("duty",        nif.duty_o, mon_e.duty);
                    chk("busy",        busy_o,     mon_e.busy);
                    chk("step",        step_o,     mon_e.step);
                end
                p_on = nif.note_on_o; p_duty = nif.duty_o; p_busy = busy_o; p_step = step_o;
            end
            if (busy_o) busy_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0, exp_busy;
        logic [7:0]  ent;
        bit          lp;
        int          hold, kind, off;

        rst_ni  = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        loop_i  = 1'b0;
`ifdef NOTE_SEQ_TEMPO_EN
        tempo_i = 8'd0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_note_on", nif.note_on_o, 0);
        chk("reset_duty",    nif.duty_o,    0);
        chk("reset_busy",    busy_o,        0);
        chk("reset_step",    step_o,        0);
        rst_ni = 1'b1;
        m_on = 0; m_duty = 0; m_busy = 0; m_step = 0;
        p_on = 0; p_duty = 0; p_busy = 0; p_step = 0;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // Full play without loop; busy time is the sum of the step periods.
        exp_busy = 0;
        for (int s = 0; s < STEPS; s++) begin
            ent = MEL[s];
            exp_busy += 1 + (int'(ent[3:0]) + 1 + GAP) * P;
        end
        b0 = busy_cnt;
        run_play(1'b0, 1, 0, 0);
        chk("busy_cycles", busy_cnt - b0, exp_busy);
        chk("end_duty", nif.duty_o, ND[1]);
        chk("end_step", step_o, STEPS - 1);

        // Loop into a second pass, stopped during its first gate.
        run_play(1'b1, 1, exp_busy + 6, 1);

        // Stop in the middle of step 2's gate, then start+stop together while idle.
        run_play(1'b0, 1, 27, 1);
        chk("stop_duty", nif.duty_o, ND[5]);
        @(negedge clk);
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_stop_idle", busy_o, 0);

        // Reset during step 0's gap, then a clean restart from step 0.
        run_play(1'b0, 1, 10, 2);
        run_play(1'b0, 2, 0, 0);

        for (int i = 0; i < 20; i++) begin
            lp   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 3);
            kind = $urandom_range(0, 2);
            if (lp && kind == 0) kind = 1;
            off  = $urandom_range(hold, lp ? 110 : 55);
            run_play(lp, hold, off, kind);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
